// File: rtl/div16by8_seq_pkg.sv
// div16by8_seq_pkg: shared state type and constants for the sequential restoring divider.
package div16by8_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int N_DEF = 8;
  localparam int CNT_W = $clog2(2 * N_DEF);
  localparam logic [2*N_DEF-1:0] DBZ_QUOT = '1;
  function automatic int cnt_w(input int n);
    return $clog2(2 * n);
  endfunction
endpackage

// File: rtl/div16by8_seq_div_step.sv
// div_step: one combinational restoring-division step (shift in a bit, trial subtract).
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   pr,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   pr_next,
  output logic         q
);
  logic [N+1:0] sh;
  always_comb begin
    sh = {pr, bit_in};
    q = sh >= {2'b00, divisor};
    pr_next = q ? (N+1)'(sh - {2'b00, divisor}) : sh[N:0];
  end
endmodule

// File: rtl/div16by8_seq.sv
// div16by8_seq: sequential 2N/N unsigned restoring divider, one quotient bit per clock.
module div16by8_seq
  import div16by8_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);
  localparam int CW = (N == N_DEF) ? CNT_W : cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);
  localparam logic [2*N-1:0] DBZ_Q = (N == N_DEF) ? (2*N)'(DBZ_QUOT) : '1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] dq;
  logic [N-1:0] dvs;
  logic [N:0] pr, pr_next;
  logic q, dbz_pend, last;
  div_step #(.N(N)) u_step (
    .pr     (pr),
    .bit_in (dq[2*N-1]),
    .divisor(dvs),
    .pr_next(pr_next),
    .q      (q)
  );
  assign last = cnt == LAST;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start ? RUN : IDLE) :
              (state == RUN)  ? (last ? DONE : RUN) : IDLE;
  end
  // A zero divisor takes a single RUN cycle (counter preset to the last step) so
  // its result lands one edge after acceptance; the step output is then discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      pr          <= '0;
      dbz_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        dq       <= dividend;
        dvs      <= divisor;
        pr       <= '0;
        dbz_pend <= divisor == '0;
        cnt      <= (divisor == '0) ? LAST : '0;
      end else if (state == RUN) begin
        dq  <= {dq[2*N-2:0], q};
        pr  <= pr_next;
        cnt <= cnt + CW'(1);
        if (last) begin
          quotient    <= dbz_pend ? DBZ_Q : {dq[2*N-2:0], q};
          remainder   <= dbz_pend ? dq[N-1:0] : pr_next[N-1:0];
          div_by_zero <= dbz_pend;
        end
      end
    end
  end
endmodule
